// File: rtl/lock_supervisor.sv
`default_nettype none
// ============================================================================
// Module   : lock_supervisor
// Purpose  : Sits between the board switches and the 11-state number-lock
//            FSM. Times the OPENING state and issues the TIMEROUT pulse that
//            ends it, counts consecutive failed entries (entries into BAD),
//            and after MAX_FAILS failures holds a timed lockout during which
//            the U/Z switches seen by the lock FSM are forced low.
// Ports    : Clk        - system clock
//            reset      - asynchronous, active-high reset
//            tick       - single-cycle slow-time enable pulse
//            U_in/Z_in  - synchronized board switches
//            opening    - lock FSM OPENING state flag
//            bad        - lock FSM BAD state flag
//            U_out/Z_out- switches forwarded to the lock FSM (gated in lockout)
//            TIMEROUT   - single-cycle pulse ending OPENING
//            locked_out - high for the whole lockout period
//            fail_count - consecutive failure count
//            timer      - remaining ticks in OPEN_T or LOCKOUT, 0 otherwise
// Revision : 1.0 - initial release
// ============================================================================
module lock_supervisor #(
  parameter int OPEN_TICKS    = 5,
  parameter int LOCKOUT_TICKS = 10,
  parameter int MAX_FAILS     = 3,
  parameter int CNT_W         = 8
) (
  input  logic             Clk,
  input  logic             reset,
  input  logic             tick,
  input  logic             U_in,
  input  logic             Z_in,
  input  logic             opening,
  input  logic             bad,
  output logic             U_out,
  output logic             Z_out,
  output logic             TIMEROUT,
  output logic             locked_out,
  output logic [3:0]       fail_count,
  output logic [CNT_W-1:0] timer
);

  localparam logic [CNT_W-1:0] c_open_ticks    = CNT_W'(OPEN_TICKS);
  localparam logic [CNT_W-1:0] c_lockout_ticks = CNT_W'(LOCKOUT_TICKS);
  localparam logic [CNT_W-1:0] c_timer_one     = CNT_W'(1);
  localparam logic [3:0]       c_max_fails     = 4'(MAX_FAILS);

  // One-hot state encoding
  typedef enum logic [3:0] {
    IDLE     = 4'b0001,
    OPEN_T   = 4'b0010,
    BAD_SEEN = 4'b0100,
    LOCKOUT  = 4'b1000
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_timer;
  logic [CNT_W-1:0] w_timer_nxt;
  logic [3:0]       r_fail_count;
  logic [3:0]       w_fail_nxt;
  logic [3:0]       w_fail_inc;
  logic             r_bad_d;
  logic             w_bad_rise;
  logic             w_timerout;

  assign w_bad_rise = bad & ~r_bad_d;

  // Saturating increment: the count can never pass MAX_FAILS, so it never wraps.
  assign w_fail_inc = (r_fail_count >= c_max_fails) ? c_max_fails
                                                    : r_fail_count + 4'd1;

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      r_state      <= IDLE;
      r_timer      <= '0;
      r_fail_count <= '0;
      r_bad_d      <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_timer      <= w_timer_nxt;
      r_fail_count <= w_fail_nxt;
      r_bad_d      <= bad;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state and timer/counter logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    w_timer_nxt = r_timer;
    w_fail_nxt  = r_fail_count;
    w_timerout  = 1'b0;

    unique case (r_state)
      IDLE: begin
        // opening takes priority: a simultaneous bad edge is ignored
        if (opening) begin
          w_state_nxt = OPEN_T;
          w_timer_nxt = c_open_ticks;
          w_fail_nxt  = '0;
        end else if (w_bad_rise) begin
          w_fail_nxt = w_fail_inc;
          if (w_fail_inc == c_max_fails) begin
            w_state_nxt = LOCKOUT;
            w_timer_nxt = c_lockout_ticks;
          end else begin
            w_state_nxt = BAD_SEEN;
          end
        end
      end

      OPEN_T: begin
        if (!opening) begin
          // lock left OPENING on its own: abandon timing, no pulse
          w_state_nxt = IDLE;
          w_timer_nxt = '0;
        end else if (tick) begin
          if (r_timer > c_timer_one) begin
            w_timer_nxt = r_timer - c_timer_one;
          end else begin
            // timer==1 fires the pulse; timer==0 is only a safe exit
            w_timerout  = (r_timer == c_timer_one);
            w_timer_nxt = '0;
            w_state_nxt = IDLE;
          end
        end
      end

      BAD_SEEN: begin
        // one count per BAD visit, however long bad stays high
        if (!bad) begin
          w_state_nxt = IDLE;
        end
      end

      LOCKOUT: begin
        if (tick) begin
          if (r_timer > c_timer_one) begin
            w_timer_nxt = r_timer - c_timer_one;
          end else begin
            w_timer_nxt = '0;
            w_fail_nxt  = '0;
            w_state_nxt = IDLE;
          end
        end
      end

      default: begin
        w_state_nxt = IDLE;
        w_timer_nxt = '0;
        w_fail_nxt  = '0;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Outputs: switch gating is combinational so it adds no latency
  // --------------------------------------------------------------------------
  assign locked_out = (r_state == LOCKOUT);
  assign U_out      = U_in & ~locked_out;
  assign Z_out      = Z_in & ~locked_out;
  assign TIMEROUT   = w_timerout;
  assign fail_count = r_fail_count;
  assign timer      = r_timer;

endmodule
`default_nettype wire

// File: tb/tb_lock_supervisor.sv
`default_nettype none
// ============================================================================
// Module   : tb_lock_supervisor
// Purpose  : Directed self-checking bench for lock_supervisor with default
//            parameters (OPEN_TICKS=5, LOCKOUT_TICKS=10, MAX_FAILS=3).
// Revision : 1.0 - initial release
// ============================================================================
module tb_lock_supervisor;

  logic       Clk;
  logic       reset;
  logic       tick;
  logic       U_in;
  logic       Z_in;
  logic       opening;
  logic       bad;
  logic       U_out;
  logic       Z_out;
  logic       TIMEROUT;
  logic       locked_out;
  logic [3:0] fail_count;
  logic [7:0] timer;

  int checks = 0;
  int errors = 0;

  lock_supervisor #(
    .OPEN_TICKS   (5),
    .LOCKOUT_TICKS(10),
    .MAX_FAILS    (3),
    .CNT_W        (8)
  ) dut (
    .Clk       (Clk),
    .reset     (reset),
    .tick      (tick),
    .U_in      (U_in),
    .Z_in      (Z_in),
    .opening   (opening),
    .bad       (bad),
    .U_out     (U_out),
    .Z_out     (Z_out),
    .TIMEROUT  (TIMEROUT),
    .locked_out(locked_out),
    .fail_count(fail_count),
    .timer     (timer)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Watchdog so the run always ends
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge
  task automatic clk1();
    @(posedge Clk);
    #1;
  endtask

  // bad high for n cycles, then low until BAD_SEEN is left, then one idle cycle
  task automatic bad_pulse(input int n);
    bad = 1'b1;
    repeat (n) clk1();
    bad = 1'b0;
    clk1();
    clk1();
  endtask

  initial begin
    reset   = 1'b1;
    tick    = 1'b0;
    U_in    = 1'b1;
    Z_in    = 1'b0;
    opening = 1'b0;
    bad     = 1'b0;
    clk1();
    clk1();
    // ---------------- reset state ----------------
    chk("rst_timerout", TIMEROUT, 0);
    chk("rst_locked", locked_out, 0);
    chk("rst_fail", fail_count, 0);
    chk("rst_timer", timer, 0);
    chk("rst_u", U_out, 1);
    chk("rst_z", Z_out, 0);
    reset = 1'b0;
    clk1();

    // ---------------- open timing ----------------
    opening = 1'b1;
    clk1();
    #1;
    chk("open_entry_timer", timer, 5);
    chk("open_entry_to", TIMEROUT, 0);
    for (int k = 1; k <= 5; k++) begin
      repeat (3) begin
        clk1();
        chk("open_gap_to", TIMEROUT, 0);
      end
      tick = 1'b1;
      #1;
      chk("open_tick_to", TIMEROUT, 32'(k == 5));
      clk1();
      tick = 1'b0;
      if (k == 5) opening = 1'b0;
      #1;
      chk("open_timer", timer, 32'(5 - k));
      chk("open_after_to", TIMEROUT, 0);
    end
    clk1();
    chk("open_idle_timer", timer, 0);
    chk("open_fail", fail_count, 0);

    // ---------------- failure counting ----------------
    bad_pulse(3);
    chk("fail_first", fail_count, 1);
    chk("fail_first_lock", locked_out, 0);
    bad_pulse(3);
    chk("fail_second", fail_count, 2);
    chk("fail_second_lock", locked_out, 0);
    opening = 1'b1;
    clk1();
    chk("fail_cleared", fail_count, 0);
    chk("fail_open_timer", timer, 5);
    opening = 1'b0;
    clk1();
    chk("fail_abort_timer", timer, 0);

    // ---------------- long bad pulse counts once ----------------
    bad_pulse(6);
    chk("long_bad_once", fail_count, 1);

    // ---------------- simultaneous opening and bad edge ----------------
    opening = 1'b1;
    bad     = 1'b1;
    clk1();
    chk("simul_fail", fail_count, 0);
    chk("simul_timer", timer, 5);
    chk("simul_lock", locked_out, 0);
    opening = 1'b0;
    bad     = 1'b0;
    clk1();
    clk1();
    chk("simul_exit_timer", timer, 0);

    // ---------------- early abort ----------------
    opening = 1'b1;
    clk1();
    repeat (2) begin
      clk1();
      tick = 1'b1;
      clk1();
      tick = 1'b0;
    end
    #1;
    chk("abort_timer_mid", timer, 3);
    opening = 1'b0;
    #1;
    chk("abort_to", TIMEROUT, 0);
    clk1();
    chk("abort_timer", timer, 0);
    tick = 1'b1;
    #1;
    chk("abort_tick_to", TIMEROUT, 0);
    clk1();
    tick = 1'b0;
    chk("abort_idle_timer", timer, 0);

    // ---------------- lockout ----------------
    U_in = 1'b1;
    Z_in = 1'b1;
    bad_pulse(2);
    bad_pulse(2);
    chk("lk_pre_fail", fail_count, 2);
    bad = 1'b1;
    #1;
    chk("lk_pre_lock", locked_out, 0);
    chk("lk_pre_u", U_out, 1);
    clk1();
    chk("lk_lock", locked_out, 1);
    chk("lk_fail", fail_count, 3);
    chk("lk_timer", timer, 10);
    chk("lk_u", U_out, 0);
    chk("lk_z", Z_out, 0);
    bad = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      clk1();
      U_in = ~U_in;
      Z_in = ~Z_in;
      #1;
      chk("lk_gate_u", U_out, 0);
      chk("lk_gate_z", Z_out, 0);
      chk("lk_hold", locked_out, 1);
      tick = 1'b1;
      clk1();
      tick = 1'b0;
      #1;
      chk("lk_timer_step", timer, 32'(10 - k));
    end
    chk("lk_end_lock", locked_out, 0);
    chk("lk_end_fail", fail_count, 0);
    chk("lk_end_u", U_out, 32'(U_in));
    U_in = ~U_in;
    Z_in = 1'b1;
    #1;
    chk("lk_follow_u", U_out, 32'(U_in));
    chk("lk_follow_z", Z_out, 1);

    // ---------------- reset mid-lockout ----------------
    U_in = 1'b1;
    bad_pulse(2);
    bad_pulse(2);
    bad = 1'b1;
    clk1();
    bad = 1'b0;
    chk("rl_lock", locked_out, 1);
    repeat (3) begin
      clk1();
      tick = 1'b1;
      clk1();
      tick = 1'b0;
    end
    #1;
    chk("rl_timer_mid", timer, 7);
    clk1();
    tick = 1'b1;
    #2;
    reset = 1'b1;
    #1;
    chk("rl_lock_clr", locked_out, 0);
    chk("rl_fail_clr", fail_count, 0);
    chk("rl_timer_clr", timer, 0);
    chk("rl_u", U_out, 1);
    clk1();
    tick  = 1'b0;
    reset = 1'b0;
    clk1();
    chk("rl_after_lock", locked_out, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/lock_supervisor.md
Name: lock_supervisor

Overview:
- Supervises the 11-state number-lock FSM and sits between the board switches and that FSM.
- Generates the TIMEROUT pulse that ends the OPENING state, after a programmable number of slow-time ticks.
- Counts consecutive failed entries (entries into BAD). After MAX_FAILS failures it enforces a timed lockout, during which switch inputs to the lock FSM are forced low.

Parameters:
OPEN_TICKS, 5, number of tick pulses the lock remains in OPENING before TIMEROUT; legal 1..2^CNT_W-1
LOCKOUT_TICKS, 10, number of tick pulses the lockout lasts; legal 1..2^CNT_W-1
MAX_FAILS, 3, consecutive BAD entries that trigger lockout; legal 1..15
CNT_W, 8, width of the tick timer

Ports:
Clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
tick  input  1  single-cycle slow-time enable pulse (e.g. from a 1 Hz divider)
U_in  input  1  U switch from board, already synchronized
Z_in  input  1  Z switch from board, already synchronized
opening  input  1  lock FSM OPENING state flag
bad  input  1  lock FSM BAD state flag
U_out  output  1  U to lock FSM
Z_out  output  1  Z to lock FSM
TIMEROUT  output  1  single-cycle pulse to lock FSM ending OPENING
locked_out  output  1  high throughout the lockout period
fail_count  output  4  current consecutive failure count
timer  output  CNT_W  remaining ticks in OPEN_T or LOCKOUT; 0 otherwise

Behaviour:
- Reset (asynchronous, active-high; clock Clk) puts all state in its initial condition:
  - state=IDLE, timer=0, fail_count=0, bad_d=0.
  - Outputs: TIMEROUT=0, locked_out=0, U_out=U_in, Z_out=Z_in.
- Reset asserted mid-operation aborts any timing or lockout immediately.
- bad_d is a register of bad. bad_rise = bad & ~bad_d.
- State machine, one-hot, 4 states: IDLE, OPEN_T, BAD_SEEN, LOCKOUT.
- IDLE:
  - If opening: go to OPEN_T, timer<=OPEN_TICKS, fail_count<=0.
  - Else if bad_rise: nf=fail_count+1.
    - If nf==MAX_FAILS: go to LOCKOUT, timer<=LOCKOUT_TICKS, fail_count<=nf.
    - Else: go to BAD_SEEN, fail_count<=nf.
  - If opening and bad_rise occur in the same cycle, opening wins and bad is ignored.
- OPEN_T:
  - On tick with timer==1: TIMEROUT=1 combinationally that cycle, timer<=0, go to IDLE.
  - On tick with timer>1: timer<=timer-1.
  - No tick: hold.
  - If opening drops before expiry: go to IDLE, timer<=0, no TIMEROUT pulse.
- BAD_SEEN: stay until bad==0, then go to IDLE. Further bad_rise events are not counted here.
- LOCKOUT:
  - locked_out=1. U_out=0 and Z_out=0 regardless of U_in/Z_in, so the FSM exits BAD to INIT and stays there.
  - On tick with timer==1: timer<=0, fail_count<=0, go to IDLE.
  - On tick with timer>1: timer<=timer-1.
- Gating outside LOCKOUT: U_out=U_in and Z_out=Z_in, combinational with zero latency.
- TIMEROUT is asserted only in OPEN_T and is never high for more than one cycle per opening.
- Counter widths:
  - fail_count saturates at MAX_FAILS and never wraps.
  - timer never underflows; a decrement from 0 cannot occur.
- Latency:
  - Lockout takes effect (locked_out=1, outputs gated) the cycle after the bad_rise that completes MAX_FAILS.
  - TIMEROUT fires in the same cycle as the OPEN_TICKS-th tick after entry to OPEN_T.

Test Plan:
- Open timing: OPEN_TICKS=5, tick every 4 cycles, opening held high. Required: exactly one TIMEROUT pulse, on the 5th tick after OPEN_T entry; timer steps 5,4,3,2,1,0; fail_count=0.
- Failure counting: MAX_FAILS=3, two bad pulses each 3 cycles wide separated by idle, then opening. Required: fail_count 1 then 2, cleared to 0 on opening; no lockout.
- Lockout: three bad pulses, LOCKOUT_TICKS=10, U_in=Z_in=1 toggling. Required: locked_out=1 from the cycle after the 3rd bad_rise; U_out=Z_out=0 throughout; after the 10th tick locked_out=0, fail_count=0, U_out follows U_in.
- Simultaneous events: opening=1 and bad rising in the same cycle in IDLE. Required: state goes to OPEN_T and fail_count is unchanged/cleared to 0. Separately, a bad pulse 6 cycles long counts once.
- Early abort: opening dropped after 2 of 5 ticks. Required: state returns to IDLE, timer=0, no TIMEROUT.
- Reset mid-lockout: assert reset at tick 4 of 10. Required: immediately locked_out=0, fail_count=0, timer=0, U_out=U_in.
